dot_product_accumulator: RTL and testbench
==========================================

Name: dot_product_accumulator

Overview:
- Downstream stage of the registered unsigned multiplier. Sums a stream of products into one dot-product result per vector and holds that result on a valid/ready output.
- The multiplier has one register stage, so the instantiating level delays valid/last by one Clock to align them with product.
- Forms the MAC lane of the matrix multiply engine; one instance per output element.

Parameters:
- W_p, 64, product width in bits (equals W_a+W_b of the upstream multiplier).
- W_g, 8, guard bits; up to 2^W_g full-scale terms sum without overflow.
- W_c, 16, term-counter width.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- in_valid  input  1  product/in_last are valid this cycle.
- in_ready  output  1  block accepts a term this cycle.
- in_last  input  1  final term of the current vector.
- product  input  W_p  unsigned term.
- out_valid  output  1  sum/out_count/out_ovf are valid.
- out_ready  input  1  consumer takes the result.
- sum  output  W_p+W_g  unsigned dot product, registered.
- out_count  output  W_c  number of terms in the result; saturates at 2^W_c-1.
- out_ovf  output  1  carry was lost during this vector.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of Clock. Inputs are ignored in a Reset cycle.
- Reset values:
  - out_valid=0, sum=0, out_count=0, out_ovf=0.
  - Internal acc=0, cnt=0, ovf=0; state=IDLE.
  - in_ready=1 in the first cycle after Reset deasserts.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. It is combinational from out_valid and out_ready only, never from in_valid or in_last.
- States (acc/cnt/ovf path):
  - IDLE: cnt==0.
  - ACCUM: at least one term has been taken and no in_last seen yet.
  - The output register has its own flag, out_valid.
- Arithmetic:
  - next = {1'b0,acc} + zero-extended product, computed at W_p+W_g+1 bits.
  - Any carry out of bit W_p+W_g-1 sets ovf (sticky within the vector). acc wraps modulo 2^(W_p+W_g).
  - cnt increments per accepted term and saturates at 2^W_c-1.
- Input transfer without in_last: acc<=next, cnt++, ovf|=carry. IDLE moves to ACCUM.
- Input transfer with in_last:
  - sum<=next, out_count<=cnt+1 (saturating), out_ovf<=ovf|carry, out_valid<=1.
  - acc, cnt and ovf clear to 0; state returns to IDLE.
  - Latency: last term accepted at edge t gives out_valid=1 with the final sum after edge t.
- Single-term vector (in_last in IDLE): sum=product, out_count=1.
- Output held: while out_valid && !out_ready, sum, out_count and out_ovf are stable and in_ready=0. Nothing is accepted, including non-last terms.
- Simultaneous output transfer and input transfer:
  - If the input term carries in_last, the output register loads the new result and out_valid stays 1. Full throughput, no bubble.
  - Otherwise out_valid<=0 and the term accumulates.
- Input bubbles: in_valid=0 cycles inside a vector leave acc, cnt and ovf unchanged.
- Reset mid-vector or mid-hold discards the partial sum and any pending result; no result is emitted.
- Output transfer without a new result: out_valid<=0; sum keeps its last value (don't-care to the consumer).

Decomposition:
- Shared package mm_pkg holds:
  - the state enum {IDLE, ACCUM};
  - default widths (W_p=64, W_g=8, W_c=16);
  - a localparam for the accumulator width, W_p+W_g.
- No sub-module is needed: the carry-extended adder and counter are inline. The upstream noOverflowMult instance stays in the lane wrapper, not inside this block.

Test Plan:
- Run all scenarios with W_p=16, W_g=2, W_c=8 unless noted.
- Reset: assert Reset 3 cycles during in_valid=1 traffic -> out_valid=0, sum=0, out_count=0, out_ovf=0, in_ready=1 after release.
- Basic vector: terms 3,5,7,9 with in_last on 9, out_ready=1 -> out_valid one cycle after the 9 is accepted, sum=24, out_count=4, out_ovf=0.
- Overflow boundary:
  - Four terms of 0xFFFF -> sum=0x3FFFC, out_ovf=0.
  - Five terms of 0xFFFF -> sum=0x0FFFB, out_ovf=1.
  - Next vector {1} -> sum=1, out_ovf=0 (sticky flag cleared).
- Backpressure: result 24 pending with out_ready=0 for 10 cycles -> sum stable, in_ready=0, in_valid terms not consumed. Raise out_ready with a single-term vector {6,last} presented -> the 6 is accepted that same cycle and out_valid stays 1 with sum=6 on the following cycle.
- Bubbles and back-to-back:
  - 2,_,_,4,_,8(last) with in_valid gaps -> sum=14, out_count=3.
  - Immediately followed by {1 last},{2 last} on consecutive cycles with out_ready=1 -> results 1 then 2 on consecutive cycles.
- Reset mid-vector: terms 10,20, then Reset, then {5,last} -> exactly one result: sum=5, out_count=1.

Source files
------------

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and default widths for the matrix multiply MAC lane
package mm_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int W_P_DEF   = 64;
    localparam int W_G_DEF   = 8;
    localparam int W_C_DEF   = 16;
    localparam int W_ACC_DEF = W_P_DEF + W_G_DEF;

endpackage

// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - sums a product stream into one dot product per vector
// Result sits in a valid/ready output register; a last term can refill it in the cycle it drains.
module dot_product_accumulator
    import mm_pkg::*;
#(
    parameter int W_p = W_P_DEF,
    parameter int W_g = W_G_DEF,
    parameter int W_c = W_C_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [W_p-1:0]     product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_p+W_g-1:0] sum,
    output logic [W_c-1:0]     out_count,
    output logic               out_ovf
);

    localparam int W_A = W_p + W_g;
    localparam logic [W_c-1:0] ONE_C = {{(W_c-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_state_next;
    logic [W_A-1:0] r_acc;
    logic [W_c-1:0] r_cnt;
    logic           r_ovf;
    logic [W_A-1:0] r_sum;
    logic [W_c-1:0] r_out_count;
    logic           r_out_ovf;
    logic           r_out_valid;

    logic [W_A:0]   w_next;
    logic           w_carry;
    logic [W_c-1:0] w_cnt_inc;
    logic           w_in_xfer;
    logic           w_in_ready;

    // Depends only on the output side, so the upstream never sees a loop through in_valid.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_in_xfer  = in_valid && w_in_ready;

    assign w_next    = {1'b0, r_acc} + {{(W_g + 1){1'b0}}, product};
    assign w_carry   = w_next[W_A];
    assign w_cnt_inc = (r_cnt == {W_c{1'b1}}) ? r_cnt : r_cnt + ONE_C;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_in_xfer && !in_last) w_state_next = ACCUM;
            ACCUM:   if (w_in_xfer && in_last)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_sum       <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_in_xfer) begin
                if (in_last) begin
                    r_sum       <= w_next[W_A-1:0];
                    r_out_count <= w_cnt_inc;
                    r_out_ovf   <= r_ovf | w_carry;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovf       <= 1'b0;
                end else begin
                    r_acc <= w_next[W_A-1:0];
                    r_cnt <= w_cnt_inc;
                    r_ovf <= r_ovf | w_carry;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb/tb_dot_product_accumulator.sv - table-driven bench for dot_product_accumulator
module tb_dot_product_accumulator;

    localparam int P = 16;
    localparam int G = 2;
    localparam int C = 8;
    localparam int A = P + G;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [P-1:0] product;
    logic         out_valid;
    logic         out_ready;
    logic [A-1:0] sum;
    logic [C-1:0] out_count;
    logic         out_ovf;

    dot_product_accumulator #(.W_p(P), .W_g(G), .W_c(C)) dut (
        .Clock     (clk),
        .Reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         iv;
        logic         il;
        logic [P-1:0] prod;
        logic         ordy;
        logic         ci;
        logic         irdy;
        logic         ov;
        logic         cr;
        logic [A-1:0] sum;
        logic [C-1:0] cnt;
        logic         ovf;
    } vec_t;

    vec_t vecs[$];
    int   nchk = 0;
    int   nfail = 0;

    task automatic add(input logic r, input logic iv, input logic il, input logic [P-1:0] p,
                       input logic ordy, input logic ci, input logic irdy, input logic ov,
                       input logic cr, input logic [A-1:0] s, input logic [C-1:0] c,
                       input logic f);
        vec_t v;
        v.rst = r; v.iv = iv; v.il = il; v.prod = p; v.ordy = ordy;
        v.ci = ci; v.irdy = irdy; v.ov = ov; v.cr = cr; v.sum = s; v.cnt = c; v.ovf = f;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic il, input logic [P-1:0] p,
                         input logic ordy);
        @(negedge clk);
        rst = r; in_valid = iv; in_last = il; product = p; out_ready = ordy;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; product = '0; out_ready = 1'b1;

        //  rst iv il prod      ordy ci irdy ov cr sum       cnt   ovf
        // reset while traffic is presented
        for (int i = 0; i < 3; i++)
            add(1, 1, i[0], 16'd7, 1, 0, 0, 0, 1, 18'd0, 8'd0, 0);
        add(0, 0, 0, 16'd0,    1, 1, 1, 0, 1, 18'd0, 8'd0, 0);
        // basic vector 3,5,7,9
        add(0, 1, 0, 16'd3,    1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 0, 16'd5,    1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 0, 16'd7,    1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 1, 16'd9,    1, 1, 1, 1, 1, 18'd24, 8'd4, 0);
        // four full-scale terms: fits exactly in the guard bits
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 16'hFFFF, 1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 1, 16'hFFFF, 1, 1, 1, 1, 1, 18'h3FFFC, 8'd4, 0);
        // five full-scale terms: carry lost
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 16'hFFFF, 1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 1, 16'hFFFF, 1, 1, 1, 1, 1, 18'h0FFFB, 8'd5, 1);
        add(0, 1, 1, 16'd1,    1, 1, 1, 1, 1, 18'd1, 8'd1, 0);
        // backpressure: build 24 with the consumer stalled
        add(0, 0, 0, 16'd0,    1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 0, 16'd3,    0, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 0, 16'd5,    0, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 0, 16'd7,    0, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 1, 16'd9,    0, 1, 1, 1, 1, 18'd24, 8'd4, 0);
        for (int i = 0; i < 10; i++)
            add(0, 1, 0, 16'd100, 0, 1, 0, 1, 1, 18'd24, 8'd4, 0);
        add(0, 1, 1, 16'd6,    1, 1, 1, 1, 1, 18'd6, 8'd1, 0);
        // bubbles inside a vector, then back-to-back single-term vectors
        add(0, 1, 0, 16'd2,    1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 0, 0, 16'd50,   1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 0, 0, 16'd50,   1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 0, 16'd4,    1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 0, 1, 16'd50,   1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 1, 16'd8,    1, 1, 1, 1, 1, 18'd14, 8'd3, 0);
        add(0, 1, 1, 16'd1,    1, 1, 1, 1, 1, 18'd1, 8'd1, 0);
        add(0, 1, 1, 16'd2,    1, 1, 1, 1, 1, 18'd2, 8'd1, 0);
        add(0, 0, 0, 16'd0,    1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        // reset mid-vector discards the partial sum
        add(0, 1, 0, 16'd10,   1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(0, 1, 0, 16'd20,   1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        add(1, 0, 0, 16'd0,    1, 0, 0, 0, 1, 18'd0, 8'd0, 0);
        add(0, 1, 1, 16'd5,    1, 1, 1, 1, 1, 18'd5, 8'd1, 0);
        add(0, 0, 0, 16'd0,    1, 1, 1, 0, 0, 18'd0, 8'd0, 0);
        // reset mid-hold drops the pending result
        add(0, 1, 1, 16'd7,    0, 1, 1, 1, 1, 18'd7, 8'd1, 0);
        add(1, 0, 0, 16'd0,    0, 1, 0, 0, 1, 18'd0, 8'd0, 0);
        add(0, 0, 0, 16'd0,    0, 1, 1, 0, 1, 18'd0, 8'd0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].il, vecs[i].prod, vecs[i].ordy);
            #1;
            if (vecs[i].ci) chk("in_ready", i, 32'(in_ready), 32'(vecs[i].irdy));
            @(posedge clk);
            #1;
            chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
            if (vecs[i].cr) begin
                chk("sum", i, 32'(sum), 32'(vecs[i].sum));
                chk("out_count", i, 32'(out_count), 32'(vecs[i].cnt));
                chk("out_ovf", i, 32'(out_ovf), 32'(vecs[i].ovf));
            end
        end

        // term counter saturates at 255 while the sum keeps counting
        for (int i = 0; i < 300; i++) drive(0, 1, i == 299, 16'd1, 1);
        @(posedge clk);
        #1;
        chk("sat_valid", 300, 32'(out_valid), 32'd1);
        chk("sat_sum", 300, 32'(sum), 32'd300);
        chk("sat_count", 300, 32'(out_count), 32'd255);
        chk("sat_ovf", 300, 32'(out_ovf), 32'd0);

        drive(0, 0, 0, 16'd0, 1);
        @(posedge clk);
        #1;
        chk("drain_valid", 301, 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
